// File: rtl/rns_domain_sequencer.sv
// rns_domain_sequencer
// Time-multiplexes one shared 8-bit residue ALU slice across all RNS domains
// of a full-width operation. One operation is accepted from the EX operand
// selection stage. One domain is issued to the slice per cycle. Results are
// written back into the full-width response in arrival (issue) order. While
// the sequencer is busy, a stall request is held towards fetch/IFID.
//
// Parameters
//   NUM_DOMAINS  number of 8-bit residue domains (1..8)
//   SLICE_LAT    slice issue-to-result latency (1..4). Informational only:
//                completion is tracked purely by i_slice_res_valid.
//   OPCODE_WID   opcode width forwarded to the slice
//   DOM_W        domain index width, max(1, clog2(NUM_DOMAINS))
//
// Ports
//   i_clk, i_reset             clock; synchronous active-low reset
//   i_req_valid/o_req_ready    request handshake
//   i_req_opcode, i_req_op1/2  opcode and full-width operands (domain d at [8d+7:8d])
//   i_req_dest                 destination register address
//   i_flush                    abort the current operation (taken branch)
//   o_slice_valid/opcode/domain/op1/op2   slice issue interface
//   i_slice_res_valid/res/cout            slice result interface (in issue order)
//   o_rsp_valid/i_rsp_ready    response handshake
//   o_rsp_result/dest/cout     assembled result, latched dest, per-domain carries
//   o_stall                    pipeline hold request
//
// Configuration macro
//   RNS_SEQ_COUT_EN  when defined, slice carry-outs are captured per domain
//                    into o_rsp_cout; otherwise o_rsp_cout is tied to zero.

module rns_domain_sequencer #(
  parameter int NUM_DOMAINS = 1,
  parameter int SLICE_LAT   = 1,
  parameter int OPCODE_WID  = 4,
  localparam int DOM_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [OPCODE_WID-1:0]    i_req_opcode,
  input  logic [NUM_DOMAINS*8-1:0] i_req_op1,
  input  logic [NUM_DOMAINS*8-1:0] i_req_op2,
  input  logic [2:0]               i_req_dest,
  input  logic                     i_flush,
  output logic                     o_slice_valid,
  output logic [OPCODE_WID-1:0]    o_slice_opcode,
  output logic [DOM_W-1:0]         o_slice_domain,
  output logic [7:0]               o_slice_op1,
  output logic [7:0]               o_slice_op2,
  input  logic                     i_slice_res_valid,
  input  logic [7:0]               i_slice_res,
  input  logic                     i_slice_cout,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [NUM_DOMAINS*8-1:0] o_rsp_result,
  output logic [2:0]               o_rsp_dest,
  output logic [NUM_DOMAINS-1:0]   o_rsp_cout,
  output logic                     o_stall
);

  localparam int W     = NUM_DOMAINS * 8;
  // Counters must be able to hold NUM_DOMAINS itself (issued / collected count).
  localparam int CNT_W = $clog2(NUM_DOMAINS + 1);
  localparam logic [CNT_W-1:0] LAST_DOM = CNT_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0] ALL_DOM  = CNT_W'(NUM_DOMAINS);
  localparam int unused_slice_lat = SLICE_LAT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_RESP,
    S_ABORT
  } state_t;

  state_t                r_state;
  logic [OPCODE_WID-1:0] r_opcode;
  logic [W-1:0]          r_op1;
  logic [W-1:0]          r_op2;
  logic [W-1:0]          r_result;
  logic [2:0]            r_dest;
  // In ISSUE/COLLECT: number of domains issued. In ABORT: results still in flight.
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [CNT_W-1:0]      r_coll_cnt;

  logic                  w_issue;
  logic                  w_collect;
  logic                  w_accept;
  logic [7:0]            w_op1_byte;
  logic [7:0]            w_op2_byte;

  // A flush kills the issue in the very cycle it is raised.
  assign w_issue   = (r_state == S_ISSUE) && !i_flush;
  assign w_collect = i_slice_res_valid && (r_coll_cnt < ALL_DOM) &&
                     ((r_state == S_ISSUE) || (r_state == S_COLLECT));
  assign w_accept  = (r_state == S_IDLE) && i_req_valid;

  // Select the residues of the domain currently being issued.
  always_comb begin
    w_op1_byte = 8'h00;
    w_op2_byte = 8'h00;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      if (r_issue_cnt == CNT_W'(d)) begin
        w_op1_byte = r_op1[d*8 +: 8];
        w_op2_byte = r_op2[d*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_result    <= '0;
      r_dest      <= '0;
      r_issue_cnt <= '0;
      r_coll_cnt  <= '0;
    end else begin
      // Results land in byte [collect counter]; arrival order equals issue order.
      if (w_collect) begin
        for (int d = 0; d < NUM_DOMAINS; d++) begin
          if (r_coll_cnt == CNT_W'(d)) begin
            r_result[d*8 +: 8] <= i_slice_res;
          end
        end
        r_coll_cnt <= r_coll_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_opcode    <= i_req_opcode;
            r_op1       <= i_req_op1;
            r_op2       <= i_req_op2;
            r_dest      <= i_req_dest;
            r_result    <= '0;
            r_issue_cnt <= '0;
            r_coll_cnt  <= '0;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (i_flush) begin
            // A result arriving in the flush cycle is already accounted as discarded.
            r_issue_cnt <= r_issue_cnt - r_coll_cnt - CNT_W'(w_collect);
            r_state     <= S_ABORT;
          end else begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            if (r_issue_cnt == LAST_DOM) begin
              r_state <= S_COLLECT;
            end
          end
        end

        S_COLLECT: begin
          if (i_flush) begin
            r_issue_cnt <= r_issue_cnt - r_coll_cnt - CNT_W'(w_collect);
            r_state     <= S_ABORT;
          end else if ((r_coll_cnt == ALL_DOM) ||
                       (w_collect && (r_coll_cnt == LAST_DOM))) begin
            r_state <= S_RESP;
          end
        end

        S_RESP: begin
          if (i_flush || i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end

        S_ABORT: begin
          if (r_issue_cnt == '0) begin
            r_state <= S_IDLE;
          end else if (i_slice_res_valid) begin
            r_issue_cnt <= r_issue_cnt - 1'b1;
            if (r_issue_cnt == CNT_W'(1)) begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RNS_SEQ_COUT_EN
  logic [NUM_DOMAINS-1:0] r_cout;

  // Carry-out captured alongside each result, cleared on accept.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cout <= '0;
    end else if (w_accept) begin
      r_cout <= '0;
    end else if (w_collect) begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        if (r_coll_cnt == CNT_W'(d)) begin
          r_cout[d] <= i_slice_cout;
        end
      end
    end
  end

  assign o_rsp_cout = r_cout;
`else
  logic w_unused_cout;
  logic w_unused_accept;

  assign w_unused_cout   = i_slice_cout;
  assign w_unused_accept = w_accept;
  assign o_rsp_cout      = '0;
`endif

  assign o_req_ready    = (r_state == S_IDLE) && i_reset;
  assign o_stall        = i_reset && ((r_state != S_IDLE) || i_req_valid);
  assign o_slice_valid  = w_issue;
  assign o_slice_opcode = r_opcode;
  assign o_slice_domain = (NUM_DOMAINS == 1) ? '0 : r_issue_cnt[DOM_W-1:0];
  assign o_slice_op1    = w_op1_byte;
  assign o_slice_op2    = w_op2_byte;
  assign o_rsp_valid    = (r_state == S_RESP);
  assign o_rsp_result   = r_result;
  assign o_rsp_dest     = r_dest;

endmodule

// File: tb/tb_rns_domain_sequencer.sv
// tb_rns_domain_sequencer
// Directed self-checking bench for rns_domain_sequencer with NUM_DOMAINS=3 and
// SLICE_LAT=2. A two-stage slice model adds residues and reports the carry.
// An extra injection path drives stray result pulses.
// Covers reset, single op timing, carry capture, response backpressure, flush
// mid-issue and reset mid-collect.

module tb_rns_domain_sequencer;

  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqValid;
  logic          reqReady;
  logic [3:0]    reqOpcode;
  logic [23:0]   reqOp1;
  logic [23:0]   reqOp2;
  logic [2:0]    reqDest;
  logic          flush;
  logic          sliceValid;
  logic [3:0]    sliceOpcode;
  logic [1:0]    sliceDomain;
  logic [7:0]    sliceOp1;
  logic [7:0]    sliceOp2;
  logic          sliceResValid;
  logic [7:0]    sliceRes;
  logic          sliceCout;
  logic          rspValid;
  logic          rspReady;
  logic [23:0]   rspResult;
  logic [2:0]    rspDest;
  logic [2:0]    rspCout;
  logic          stall;

  int checkCount = 0;
  int passCount  = 0;

  // Slice model: adder with two register stages plus a stray-pulse injector.
  logic          s0Valid = 1'b0, s1Valid = 1'b0;
  logic [7:0]    s0Res = 8'h00, s1Res = 8'h00;
  logic          s0Cout = 1'b0, s1Cout = 1'b0;
  logic          strayValid;
  logic [8:0]    sliceSum;

  assign sliceSum      = {1'b0, sliceOp1} + {1'b0, sliceOp2};
  assign sliceResValid = s1Valid | strayValid;
  assign sliceRes      = strayValid ? 8'hEE : s1Res;
  assign sliceCout     = strayValid ? 1'b1 : s1Cout;

  always @(posedge clk) begin
    s0Valid <= sliceValid;
    s0Res   <= sliceSum[7:0];
    s0Cout  <= sliceSum[8];
    s1Valid <= s0Valid;
    s1Res   <= s0Res;
    s1Cout  <= s0Cout;
  end

  always #5 clk = ~clk;

  rns_domain_sequencer #(
    .NUM_DOMAINS(ND),
    .SLICE_LAT  (2),
    .OPCODE_WID (4)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_req_valid      (reqValid),
    .o_req_ready      (reqReady),
    .i_req_opcode     (reqOpcode),
    .i_req_op1        (reqOp1),
    .i_req_op2        (reqOp2),
    .i_req_dest       (reqDest),
    .i_flush          (flush),
    .o_slice_valid    (sliceValid),
    .o_slice_opcode   (sliceOpcode),
    .o_slice_domain   (sliceDomain),
    .o_slice_op1      (sliceOp1),
    .o_slice_op2      (sliceOp2),
    .i_slice_res_valid(sliceResValid),
    .i_slice_res      (sliceRes),
    .i_slice_cout     (sliceCout),
    .o_rsp_valid      (rspValid),
    .i_rsp_ready      (rspReady),
    .o_rsp_result     (rspResult),
    .o_rsp_dest       (rspDest),
    .o_rsp_cout       (rspCout),
    .o_stall          (stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one complete operation: accept, issue order, latency, optional
  // response backpressure for holdCycles, then the handshake.
  task automatic applyStimulus(input string tag, input logic [3:0] opc,
                               input logic [23:0] a, input logic [23:0] b,
                               input logic [2:0] dest, input int holdCycles,
                               input logic [23:0] expRes, input logic [2:0] expCout);
    int n;
    @(negedge clk);
    reqValid  = 1'b1;
    reqOpcode = opc;
    reqOp1    = a;
    reqOp2    = b;
    reqDest   = dest;
    rspReady  = (holdCycles == 0);
    #1;
    checkOutput({tag, "_readyIdle"}, {31'b0, reqReady}, 32'd1);
    checkOutput({tag, "_stallReq"}, {31'b0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    n = 0;
    while (!rspValid && n < 20) begin
      if (n < ND) begin
        checkOutput({tag, "_sliceValid"}, {31'b0, sliceValid}, 32'd1);
        checkOutput({tag, "_sliceDomain"}, {30'b0, sliceDomain}, n);
        checkOutput({tag, "_sliceOp1"}, {24'b0, sliceOp1}, {24'b0, a[n*8 +: 8]});
        checkOutput({tag, "_sliceOpcode"}, {28'b0, sliceOpcode}, {28'b0, opc});
      end else if (n == ND) begin
        checkOutput({tag, "_sliceIdle"}, {31'b0, sliceValid}, 32'd0);
      end
      checkOutput({tag, "_stallBusy"}, {31'b0, stall}, 32'd1);
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, n, 32'd5);
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput({tag, "_holdValid"}, {31'b0, rspValid}, 32'd1);
      checkOutput({tag, "_holdResult"}, {8'b0, rspResult}, {8'b0, expRes});
      checkOutput({tag, "_holdReady"}, {31'b0, reqReady}, 32'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    checkOutput({tag, "_rspValid"}, {31'b0, rspValid}, 32'd1);
    checkOutput({tag, "_rspResult"}, {8'b0, rspResult}, {8'b0, expRes});
    checkOutput({tag, "_rspDest"}, {29'b0, rspDest}, {29'b0, dest});
    checkOutput({tag, "_rspCout"}, {29'b0, rspCout}, {29'b0, expCout});
    checkOutput({tag, "_rspStall"}, {31'b0, stall}, 32'd1);
    checkOutput({tag, "_rspReqReady"}, {31'b0, reqReady}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput({tag, "_doneValid"}, {31'b0, rspValid}, 32'd0);
    checkOutput({tag, "_doneReady"}, {31'b0, reqReady}, 32'd1);
    checkOutput({tag, "_doneStall"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] carryExp;
`ifdef RNS_SEQ_COUT_EN
    carryExp = 3'b101;
`else
    carryExp = 3'b000;
`endif
    reset      = 1'b0;
    reqValid   = 1'b0;
    reqOpcode  = 4'h0;
    reqOp1     = 24'h0;
    reqOp2     = 24'h0;
    reqDest    = 3'd0;
    flush      = 1'b0;
    rspReady   = 1'b0;
    strayValid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_reqReady", {31'b0, reqReady}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_readyAfter", {31'b0, reqReady}, 32'd1);
    checkOutput("rst_rspValid", {31'b0, rspValid}, 32'd0);
    checkOutput("rst_sliceValid", {31'b0, sliceValid}, 32'd0);
    checkOutput("rst_rspResult", {8'b0, rspResult}, 32'd0);

    // Single op, carry, backpressure
    applyStimulus("single", 4'h1, 24'h302010, 24'h030201, 3'd5, 0, 24'h332211, 3'b000);
    applyStimulus("carry", 4'h2, 24'hFF00FF, 24'h010001, 3'd2, 0, 24'h000000, carryExp);
    applyStimulus("bkpr", 4'h3, 24'h123456, 24'h111111, 3'd7, 4, 24'h234567, 3'b000);

    // Flush during the cycle of the third issue
    @(negedge clk);
    reqValid = 1'b1;
    reqOpcode = 4'h4;
    reqOp1 = 24'h0A0B0C;
    reqOp2 = 24'h010101;
    reqDest = 3'd4;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("flush_issue0", {31'b0, sliceValid}, 32'd1);
    @(negedge clk);
    checkOutput("flush_issue1", {30'b0, sliceDomain}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush_noIssue2", {31'b0, sliceValid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_abortBusy", {31'b0, reqReady}, 32'd0);
    checkOutput("flush_abortSlice", {31'b0, sliceValid}, 32'd0);
    checkOutput("flush_abortRsp", {31'b0, rspValid}, 32'd0);
    @(negedge clk);
    checkOutput("flush_idle", {31'b0, reqReady}, 32'd1);
    checkOutput("flush_stall", {31'b0, stall}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("flush_noRsp", {31'b0, rspValid}, 32'd0);
    end
    applyStimulus("postFlush", 4'h5, 24'h050607, 24'h101010, 3'd1, 0, 24'h151617, 3'b000);

    // Reset while in COLLECT
    @(negedge clk);
    reqValid = 1'b1;
    reqOpcode = 4'h6;
    reqOp1 = 24'h445566;
    reqOp2 = 24'h010203;
    reqDest = 3'd6;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstMid_reqReady", {31'b0, reqReady}, 32'd0);
    checkOutput("rstMid_sliceValid", {31'b0, sliceValid}, 32'd0);
    checkOutput("rstMid_rspValid", {31'b0, rspValid}, 32'd0);
    checkOutput("rstMid_stall", {31'b0, stall}, 32'd0);
    checkOutput("rstMid_rspResult", {8'b0, rspResult}, 32'd0);
    checkOutput("rstMid_rspDest", {29'b0, rspDest}, 32'd0);
    checkOutput("rstMid_rspCout", {29'b0, rspCout}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    strayValid = 1'b1;
    repeat (2) @(negedge clk);
    strayValid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stray_noRsp", {31'b0, rspValid}, 32'd0);
      checkOutput("stray_idle", {31'b0, reqReady}, 32'd1);
    end
    applyStimulus("postReset", 4'h7, 24'h7F8081, 24'h010101, 3'd3, 0, 24'h808182, 3'b000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
